// File: rtl/sync_fifo_wconv_pkg.sv
// Shared helpers for sync_fifo_wconv: clog2, width-ratio derivation and parameter legality.
package sync_fifo_wconv_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int calc_ratio(input int wr_width, input int rd_width);
    return (rd_width > 0) ? (wr_width / rd_width) : 1;
  endfunction

  // Lane index is kept at least one bit wide so a 1:1 ratio still has a legal select.
  function automatic int calc_lane_w(input int ratio);
    return (clog2(ratio) == 0) ? 1 : clog2(ratio);
  endfunction

  function automatic bit params_legal(input int wr_width, input int rd_width, input int depth_width);
    int ratio;
    ratio = calc_ratio(wr_width, rd_width);
    return (rd_width > 0) && (wr_width == ratio * rd_width) &&
           (ratio >= 1) && (ratio <= 64) && ((ratio & (ratio - 1)) == 0) &&
           (depth_width > clog2(ratio));
  endfunction

endpackage

// File: rtl/sync_fifo_wconv_ram.sv
// Simple dual-port storage: one wide write word in, one narrow lane out.
// Registered read in standard mode, asynchronous read in FWFT mode.
module sync_fifo_wconv_ram
  import sync_fifo_wconv_pkg::*;
#(
  parameter int c_WR_DATA_WIDTH  = 256,
  parameter int c_RD_DATA_WIDTH  = 16,
  parameter int c_RD_DEPTH_WIDTH = 9,
  parameter int c_FWFT           = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [c_RD_DEPTH_WIDTH-clog2(calc_ratio(c_WR_DATA_WIDTH, c_RD_DATA_WIDTH))-1:0] wr_addr,
  input  logic [c_WR_DATA_WIDTH-1:0]             wr_data,
  input  logic                                   rd_en,
  input  logic [c_RD_DEPTH_WIDTH-1:0]            rd_addr,
  output logic [c_RD_DATA_WIDTH-1:0]             rd_data
);

  localparam int RATIO = calc_ratio(c_WR_DATA_WIDTH, c_RD_DATA_WIDTH);
  localparam int SHIFT = clog2(RATIO);
  localparam int LW    = calc_lane_w(RATIO);
  localparam int WA    = c_RD_DEPTH_WIDTH - SHIFT;

  logic [RATIO-1:0][c_RD_DATA_WIDTH-1:0] mem [2**WA];
  logic [WA-1:0]                         rd_word;
  logic [LW-1:0]                         rd_lane;
  logic [c_RD_DATA_WIDTH-1:0]            rd_word_lane;

  assign rd_word = rd_addr[c_RD_DEPTH_WIDTH-1:SHIFT];

  if (SHIFT > 0) begin : g_lane
    assign rd_lane = rd_addr[SHIFT-1:0];
  end else begin : g_no_lane
    assign rd_lane = '0;
  end

  assign rd_word_lane = mem[rd_word][rd_lane];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (c_FWFT != 0) begin : g_async_rd
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst ^ rd_en;
    assign rd_data        = rd_word_lane;
  end else begin : g_sync_rd
    logic [c_RD_DATA_WIDTH-1:0] rd_data_q;
    logic [c_RD_DATA_WIDTH-1:0] rd_data_d;
    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
        rd_data_d = rd_word_lane;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end
    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/sync_fifo_wconv.sv
// Synchronous width-converting FIFO: wide writes, narrow lane-0-first reads.
// Optional sticky overflow/underflow flags under macro SYNC_FIFO_WCONV_ERR_FLAG_EN.
module sync_fifo_wconv
  import sync_fifo_wconv_pkg::*;
#(
  parameter int c_WR_DATA_WIDTH    = 256,
  parameter int c_RD_DATA_WIDTH    = 16,
  parameter int c_RD_DEPTH_WIDTH   = 9,
  parameter int c_ALMOST_FULL_NUM  = 30,
  parameter int c_ALMOST_EMPTY_NUM = 4,
  parameter int c_FWFT             = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [c_WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                        wr_en,
  output logic                        wr_full,
  output logic                        almost_full,
  output logic [c_RD_DEPTH_WIDTH:0]   wr_water_level,
  output logic [c_RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                        rd_en,
  output logic                        rd_empty,
  output logic                        almost_empty,
  output logic [c_RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int D     = c_RD_DEPTH_WIDTH;
  localparam int RATIO = calc_ratio(c_WR_DATA_WIDTH, c_RD_DATA_WIDTH);
  localparam int SHIFT = clog2(RATIO);
  localparam logic [D:0] FULL_LIMIT = (D+1)'((2**D) - RATIO);

  if (!params_legal(c_WR_DATA_WIDTH, c_RD_DATA_WIDTH, c_RD_DEPTH_WIDTH)) begin : g_param_check
    $error("sync_fifo_wconv: illegal width/depth parameter combination");
  end

  logic [D:0]                 count_q, count_d;
  logic [D-1:0]               wr_ptr_q, wr_ptr_d;
  logic [D-1:0]               rd_ptr_q, rd_ptr_d;
  logic                       wr_accept, rd_accept;
  logic [c_RD_DATA_WIDTH-1:0] ram_rd_data;

  assign wr_full        = count_q > FULL_LIMIT;
  assign rd_empty       = count_q == '0;
  assign rd_water_level = count_q;
  assign wr_water_level = count_q >> SHIFT;
  assign almost_full    = wr_water_level >= (D+1)'(c_ALMOST_FULL_NUM);
  assign almost_empty   = count_q <= (D+1)'(c_ALMOST_EMPTY_NUM);
  assign wr_accept      = wr_en & ~wr_full;
  assign rd_accept      = rd_en & ~rd_empty;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (D+1)'(RATIO);
      2'b01:   count_d = count_q - (D+1)'(1);
      2'b11:   count_d = count_q + (D+1)'(RATIO) - (D+1)'(1);
      default: count_d = count_q;
    endcase
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + D'(RATIO);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + D'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_wconv_ram #(
    .c_WR_DATA_WIDTH  (c_WR_DATA_WIDTH),
    .c_RD_DATA_WIDTH  (c_RD_DATA_WIDTH),
    .c_RD_DEPTH_WIDTH (c_RD_DEPTH_WIDTH),
    .c_FWFT           (c_FWFT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept & ~rst),
    .wr_addr (wr_ptr_q[D-1:SHIFT]),
    .wr_data (wr_data),
    .rd_en   (rd_accept & ~rst),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // In FWFT the async head is only meaningful while non-empty; otherwise show the last word read.
  if (c_FWFT != 0) begin : g_fwft
    logic [c_RD_DATA_WIDTH-1:0] hold_q, hold_d;
    always_comb begin
      hold_d = hold_q;
      if (rd_accept) begin
        hold_d = ram_rd_data;
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
      end else begin
        hold_q <= hold_d;
      end
    end
    assign rd_data = rd_empty ? hold_q : ram_rd_data;
  end else begin : g_std
    assign rd_data = ram_rd_data;
  end

`ifdef SYNC_FIFO_WCONV_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en & wr_full);
    underflow_d = underflow_q | (rd_en & rd_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Randomized self-checking bench for sync_fifo_wconv: a standard and an FWFT instance
// share one stimulus stream and are compared against a queue-based reference model.
module tb_sync_fifo_wconv;

  localparam int DEPTH = 512;
  localparam int RATIO = 16;
  localparam int AF    = 30;
  localparam int AE    = 4;
`ifdef SYNC_FIFO_WCONV_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [255:0] wr_data;

  logic        s_wr_full, s_almost_full, s_rd_empty, s_almost_empty, s_overflow, s_underflow;
  logic [9:0]  s_wr_level, s_rd_level;
  logic [15:0] s_rd_data;
  logic        f_wr_full, f_almost_full, f_rd_empty, f_almost_empty, f_overflow, f_underflow;
  logic [9:0]  f_wr_level, f_rd_level;
  logic [15:0] f_rd_data;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] model_q[$];
  logic [15:0] exp_std;
  logic [15:0] exp_hold;
  bit          exp_ovf;
  bit          exp_unf;

  always #5 clk = ~clk;

  sync_fifo_wconv #(
    .c_WR_DATA_WIDTH(256), .c_RD_DATA_WIDTH(16), .c_RD_DEPTH_WIDTH(9),
    .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE), .c_FWFT(0)
  ) dut_std (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(s_wr_full), .almost_full(s_almost_full), .wr_water_level(s_wr_level),
    .rd_data(s_rd_data), .rd_en(rd_en), .rd_empty(s_rd_empty),
    .almost_empty(s_almost_empty), .rd_water_level(s_rd_level),
    .overflow(s_overflow), .underflow(s_underflow)
  );

  sync_fifo_wconv #(
    .c_WR_DATA_WIDTH(256), .c_RD_DATA_WIDTH(16), .c_RD_DEPTH_WIDTH(9),
    .c_ALMOST_FULL_NUM(AF), .c_ALMOST_EMPTY_NUM(AE), .c_FWFT(1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(f_wr_full), .almost_full(f_almost_full), .wr_water_level(f_wr_level),
    .rd_data(f_rd_data), .rd_en(rd_en), .rd_empty(f_rd_empty),
    .almost_empty(f_almost_empty), .rd_water_level(f_rd_level),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected outputs come straight from the queue occupancy and the last word popped.
  task automatic checkAll();
    int          n;
    logic [15:0] fwft_exp;
    n        = model_q.size();
    fwft_exp = (n == 0) ? exp_hold : model_q[0];
    checkOutput("rd_water_level",  32'(s_rd_level),     32'(n));
    checkOutput("wr_water_level",  32'(s_wr_level),     32'(n / RATIO));
    checkOutput("wr_full",         32'(s_wr_full),      32'(n > DEPTH - RATIO));
    checkOutput("almost_full",     32'(s_almost_full),  32'((n / RATIO) >= AF));
    checkOutput("rd_empty",        32'(s_rd_empty),     32'(n == 0));
    checkOutput("almost_empty",    32'(s_almost_empty), 32'(n <= AE));
    checkOutput("std_rd_data",     32'(s_rd_data),      32'(exp_std));
    checkOutput("overflow",        32'(s_overflow),     32'(ERR_EN & exp_ovf));
    checkOutput("underflow",       32'(s_underflow),    32'(ERR_EN & exp_unf));
    checkOutput("fwft_rd_data",    32'(f_rd_data),      32'(fwft_exp));
    checkOutput("fwft_rd_empty",   32'(f_rd_empty),     32'(n == 0));
    checkOutput("fwft_rd_level",   32'(f_rd_level),     32'(n));
    checkOutput("fwft_flags",
                32'({f_wr_full, f_almost_full, f_almost_empty, f_overflow, f_underflow}),
                32'({n > DEPTH - RATIO, (n / RATIO) >= AF, n <= AE, ERR_EN & exp_ovf, ERR_EN & exp_unf}));
    checkOutput("fwft_wr_level",   32'(f_wr_level),     32'(n / RATIO));
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic applyStimulus(input logic w, input logic r, input logic [255:0] d, input logic rs);
    bit full;
    bit empty;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      exp_std  = '0;
      exp_hold = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      full  = model_q.size() > DEPTH - RATIO;
      empty = model_q.size() == 0;
      if (r && !empty) begin
        exp_std  = model_q.pop_front();
        exp_hold = exp_std;
      end
      if (w && !full) begin
        for (int i = 0; i < RATIO; i++) model_q.push_back(d[i*16 +: 16]);
      end
      if (w && full)  exp_ovf = 1'b1;
      if (r && empty) exp_unf = 1'b1;
    end
    @(negedge clk);
    checkAll();
  endtask

  function automatic logic [255:0] randWord();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [255:0] laneWord(input logic [15:0] base);
    logic [255:0] w;
    for (int i = 0; i < RATIO; i++) w[i*16 +: 16] = base + 16'(i);
    return w;
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_q.delete();
    exp_std = '0; exp_hold = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, randWord(), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("reset_levels", 32'({s_rd_level, s_wr_level}), 32'd0);
    checkOutput("reset_flags", 32'({s_rd_empty, s_almost_empty, s_wr_full, s_almost_full}), 32'b1100);

    $display("[TB] lane order");
    applyStimulus(1'b1, 1'b0, laneWord(16'h1000), 1'b0);
    checkOutput("first_write_not_empty", 32'(s_rd_empty), 32'd0);
    for (int i = 0; i < RATIO; i++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
      checkOutput("lane_order", 32'(s_rd_data), 32'(16'h1000 + i));
    end
    checkOutput("empty_after_16", 32'(s_rd_empty), 32'd1);

    $display("[TB] fill to full");
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
    checkOutput("full_flag", 32'(s_wr_full), 32'd1);
    checkOutput("full_wr_level", 32'(s_wr_level), 32'd32);
    checkOutput("full_rd_level", 32'(s_rd_level), 32'd512);
    applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
    checkOutput("ignored_33rd", 32'(s_rd_level), 32'd512);
    checkOutput("overflow_set", 32'(s_overflow), 32'(ERR_EN));
    applyStimulus(1'b1, 1'b1, randWord(), 1'b0);
    checkOutput("full_wr_rd", 32'(s_rd_level), 32'd511);

    $display("[TB] simultaneous at 100");
    for (int i = 0; i < 411; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    checkOutput("level_100", 32'(s_rd_level), 32'd100);
    applyStimulus(1'b1, 1'b1, randWord(), 1'b0);
    checkOutput("simul_rd_level", 32'(s_rd_level), 32'd115);
    checkOutput("simul_wr_level", 32'(s_wr_level), 32'd7);

    $display("[TB] empty read");
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, laneWord(16'hA000), 1'b0);
    for (int i = 0; i < RATIO; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    checkOutput("empty_rd_hold", 32'(s_rd_data), 32'h0000A00F);
    checkOutput("empty_rd_level", 32'(s_rd_level), 32'd0);
    checkOutput("underflow_set", 32'(s_underflow), 32'(ERR_EN));

    $display("[TB] mid-operation reset");
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
    checkOutput("level_200", 32'(s_rd_level), 32'd200);
    applyStimulus(1'b1, 1'b1, randWord(), 1'b1);
    checkOutput("rst_level", 32'(s_rd_level), 32'd0);
    checkOutput("rst_empty_full", 32'({s_rd_empty, s_wr_full}), 32'b10);
    checkOutput("rst_rd_data", 32'(s_rd_data), 32'd0);
    applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
    for (int i = 0; i < RATIO; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);

    $display("[TB] fwft stepping");
    applyStimulus(1'b1, 1'b0, laneWord(16'hB000), 1'b0);
    checkOutput("fwft_first", 32'(f_rd_data), 32'h0000B000);
    for (int k = 0; k < RATIO - 1; k++) begin
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("fwft_step", 32'(f_rd_data), 32'(16'hB001 + k));
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      int wr_pct;
      wr_pct = ((i / 500) % 2 == 0) ? 20 : 70;
      applyStimulus($urandom_range(99) < wr_pct, $urandom_range(99) < 60,
                    randWord(), $urandom_range(299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
